// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and constants for the ARC4 datapath stages.
//   state_e      - PRGA controller states
//   MEM_DEPTH    - entries in S/CT/PT memories
//   ADDR_W       - memory address width derived from MEM_DEPTH
//   ASCII_LO/HI  - printable plaintext window used by the optional pt_ok flag
package arc4_pkg;

   localparam int unsigned MEM_DEPTH = 256;
   localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);

   localparam logic [7:0] ASCII_LO = 8'h20;
   localparam logic [7:0] ASCII_HI = 8'h7E;

   typedef enum logic [3:0] {
      StIdle,
      StRdLen,
      StWrLen,
      StRdSi,
      StRdSj,
      StWrSi,
      StWrSj,
      StRdPad,
      StRdCt,
      StWrPt
   } state_e;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= ASCII_LO) && (b <= ASCII_HI);
   endfunction

endpackage

// File: rtl/arc4_prga.sv
// arc4_prga: ARC4 pseudo-random generation + XOR stage.
// Reads the length byte from ct[0], copies it to pt[0], then for each byte k=1..len runs the
// ARC4 i/j update, swaps s[i]/s[j] in place and writes pt[k] = s[s[i]+s[j]] ^ ct[k].
// All memories are synchronous-read (data valid the cycle after the address).
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous reset, active HIGH despite the name
//   en / rdy   - start handshake; en is only honoured while rdy=1
//   key        - unused here, kept for a uniform stage interface
//   s_*        - S memory port (addr, read data, write data, write enable)
//   ct_*       - ciphertext memory read port
//   pt_*       - plaintext memory port (read data unused)
//   pt_ok      - only with ARC4_PT_ASCII_CHECK_EN defined: 1 while every pt[k>=1] of the
//                last run was printable ASCII; valid while rdy=1
module arc4_prga
   import arc4_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic              rdy,
   input  logic [23:0]       key,
   output logic [ADDR_W-1:0] s_addr,
   input  logic [7:0]        s_rddata,
   output logic [7:0]        s_wrdata,
   output logic              s_wren,
   output logic [ADDR_W-1:0] ct_addr,
   input  logic [7:0]        ct_rddata,
   output logic [ADDR_W-1:0] pt_addr,
   input  logic [7:0]        pt_rddata,
   output logic [7:0]        pt_wrdata,
`ifdef ARC4_PT_ASCII_CHECK_EN
   output logic              pt_ok,
`endif
   output logic              pt_wren
);

   state_e      state_q, state_d;
   logic        ph_q, ph_d;        // 0: address issued, 1: read data valid
   logic [7:0]  i_q, i_d;
   logic [7:0]  j_q, j_d;
   logic [7:0]  k_q, k_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  si_q, si_d;
   logic [7:0]  sj_q, sj_d;
   logic [7:0]  pad_q, pad_d;
   logic [7:0]  ct_q, ct_d;

   logic unused_inputs;
   assign unused_inputs = ^{key, pt_rddata};

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= StIdle;
         ph_q    <= 1'b0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         len_q   <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         pad_q   <= '0;
         ct_q    <= '0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         len_q   <= len_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         pad_q   <= pad_d;
         ct_q    <= ct_d;
      end
   end

   // Next-state. Read states spend two cycles: ph_q=0 issues the address, ph_q=1 captures.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      len_d   = len_q;
      si_d    = si_q;
      sj_d    = sj_q;
      pad_d   = pad_q;
      ct_d    = ct_q;

      case (state_q)
         StIdle: begin
            if (en) begin
               state_d = StRdLen;
               ph_d    = 1'b0;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
            end
         end
         StRdLen: begin
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d    = 1'b0;
               len_d   = ct_rddata;
               state_d = StWrLen;
            end
         end
         StWrLen: begin
            if (len_q == 8'd0) begin
               state_d = StIdle;
            end else begin
               i_d     = 8'd1;
               k_d     = 8'd1;
               state_d = StRdSi;
            end
         end
         StRdSi: begin
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d    = 1'b0;
               si_d    = s_rddata;
               j_d     = j_q + s_rddata;
               state_d = StRdSj;
            end
         end
         StRdSj: begin
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d    = 1'b0;
               sj_d    = s_rddata;
               state_d = StWrSi;
            end
         end
         StWrSi: state_d = StWrSj;
         StWrSj: state_d = StRdPad;
         StRdPad: begin
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d    = 1'b0;
               pad_d   = s_rddata;
               state_d = StRdCt;
            end
         end
         StRdCt: begin
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d    = 1'b0;
               ct_d    = ct_rddata;
               state_d = StWrPt;
            end
         end
         StWrPt: begin
            // Compare before incrementing so len=255 terminates without k wrapping.
            if (k_q == len_q) begin
               state_d = StIdle;
            end else begin
               i_d     = i_q + 8'd1;
               k_d     = k_q + 8'd1;
               state_d = StRdSi;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Moore outputs; everything is zero in StIdle so reset drives all buses low.
   always_comb begin
      rdy       = 1'b0;
      s_addr    = '0;
      s_wrdata  = '0;
      s_wren    = 1'b0;
      ct_addr   = '0;
      pt_addr   = '0;
      pt_wrdata = '0;
      pt_wren   = 1'b0;

      case (state_q)
         StIdle:  rdy = 1'b1;
         StRdLen: ct_addr = '0;
         StWrLen: begin
            pt_addr   = '0;
            pt_wrdata = len_q;
            pt_wren   = 1'b1;
         end
         StRdSi:  s_addr = i_q;
         StRdSj:  s_addr = j_q;
         StWrSi: begin
            s_addr   = i_q;
            s_wrdata = sj_q;
            s_wren   = 1'b1;
         end
         StWrSj: begin
            s_addr   = j_q;
            s_wrdata = si_q;
            s_wren   = 1'b1;
         end
         // Registered s[i]/s[j] give the pad index; no re-read after the swap.
         StRdPad: s_addr = si_q + sj_q;
         StRdCt:  ct_addr = k_q;
         StWrPt: begin
            pt_addr   = k_q;
            pt_wrdata = pad_q ^ ct_q;
            pt_wren   = 1'b1;
         end
         default: rdy = 1'b0;
      endcase
   end

`ifdef ARC4_PT_ASCII_CHECK_EN
   logic pt_ok_q, pt_ok_d;

   always_comb begin
      pt_ok_d = pt_ok_q;
      if (state_q == StIdle && en) begin
         pt_ok_d = 1'b1;
      end else if (state_q == StWrPt && !is_printable(pt_wrdata)) begin
         pt_ok_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         pt_ok_q <= 1'b1;
      end else begin
         pt_ok_q <= pt_ok_d;
      end
   end

   assign pt_ok = pt_ok_q;
`endif

endmodule

// File: tb/tb_arc4_prga.sv
// tb_arc4_prga: self-checking bench for arc4_prga with behavioural memories and a software
// ARC4 model. Define ARC4_PT_ASCII_CHECK_EN to also exercise pt_ok.
module tb_arc4_prga;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic        rdy;
   logic [23:0] key = 24'h1234ab;
   logic [7:0]  s_addr, s_rddata, s_wrdata;
   logic        s_wren;
   logic [7:0]  ct_addr, ct_rddata;
   logic [7:0]  pt_addr, pt_wrdata;
   logic [7:0]  pt_rddata = 8'h00;
   logic        pt_wren;
`ifdef ARC4_PT_ASCII_CHECK_EN
   logic        pt_ok;
`endif

   always #5 clk = ~clk;

   arc4_prga dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rdy       (rdy),
      .key       (key),
      .s_addr    (s_addr),
      .s_rddata  (s_rddata),
      .s_wrdata  (s_wrdata),
      .s_wren    (s_wren),
      .ct_addr   (ct_addr),
      .ct_rddata (ct_rddata),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .pt_wrdata (pt_wrdata),
`ifdef ARC4_PT_ASCII_CHECK_EN
      .pt_ok     (pt_ok),
`endif
      .pt_wren   (pt_wren)
   );

   // Memories
   logic [7:0] s_mem  [256];
   logic [7:0] ct_mem [256];
   logic [7:0] pt_mem [256];
   logic [7:0] init_s [256];
   logic       load = 1'b0;

   always @(posedge clk) begin
      s_rddata  <= s_mem[s_addr];
      ct_rddata <= ct_mem[ct_addr];
      if (load) begin
         for (int x = 0; x < 256; x++) begin
            s_mem[x]  <= init_s[x];
            pt_mem[x] <= 8'h00;
         end
      end else begin
         if (s_wren)  s_mem[s_addr]   <= s_wrdata;
         if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Software ARC4 model
   logic [7:0] exp_pt [256];
   logic [7:0] exp_s  [256];
   int         exp_len = 0;

   task automatic model_run();
      logic [7:0] s [256];
      logic [7:0] t;
      int i, j;
      for (int x = 0; x < 256; x++) s[x] = init_s[x];
      exp_len   = int'(ct_mem[0]);
      exp_pt[0] = ct_mem[0];
      i = 0;
      j = 0;
      for (int k = 1; k <= exp_len; k++) begin
         i = (i + 1) % 256;
         j = (j + int'(s[i])) % 256;
         t = s[i];
         s[i] = s[j];
         s[j] = t;
         exp_pt[k] = s[(int'(s[i]) + int'(s[j])) % 256] ^ ct_mem[k];
      end
      for (int x = 0; x < 256; x++) exp_s[x] = s[x];
   endtask

   // Compare process: every PT write against the model, no writes while idle
   int         wr_idx = 0;
   int         s_wr_cnt = 0;
   int         starts = 0;
   logic       chk_on = 1'b0;
   logic       prev_rdy = 1'b1;
   logic [7:0] snap_s1, snap_s2, snap_s3;

   always @(negedge clk) begin
      if (!rst_n && chk_on) begin
         if (pt_wren) begin
            if (wr_idx <= exp_len) begin
               check($sformatf("pt_wr_addr[%0d]", wr_idx), pt_addr, wr_idx);
               check($sformatf("pt_wr_data[%0d]", wr_idx), pt_wrdata, exp_pt[wr_idx]);
            end else begin
               checks++;
               failures++;
               $display("FAIL pt_extra_write: addr 0x%0h after len %0d", pt_addr, exp_len);
            end
            if (pt_addr == 8'd1) snap_s1 = s_mem[1];
            if (pt_addr == 8'd2) begin
               snap_s2 = s_mem[2];
               snap_s3 = s_mem[3];
            end
            wr_idx++;
         end
         if (s_wren) s_wr_cnt++;
         if (rdy) check("idle_no_write", {s_wren, pt_wren}, 2'b00);
      end
      if (!rst_n && prev_rdy && !rdy) starts++;
      prev_rdy = rdy;
   end

   task automatic do_load();
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic arm();
      wr_idx   = 0;
      s_wr_cnt = 0;
      starts   = 0;
      chk_on   = 1'b1;
   endtask

   task automatic run(input int en_cycles, input int budget, input string name,
                      output int cycles);
      @(negedge clk);
      en = 1'b1;
      repeat (en_cycles) @(negedge clk);
      en = 1'b0;
      cycles = en_cycles;
      while (rdy !== 1'b1 && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      if (rdy !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: rdy=%b after %0d cycles", name, rdy, cycles);
      end
   endtask

   task automatic check_all(input string name);
      for (int x = 0; x <= exp_len; x++)
         check($sformatf("%s_pt[%0d]", name, x), pt_mem[x], exp_pt[x]);
      for (int x = 0; x < 256; x++)
         check($sformatf("%s_s[%0d]", name, x), s_mem[x], exp_s[x]);
      check({name, "_pt_writes"}, wr_idx, exp_len + 1);
      check({name, "_starts"}, starts, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
`ifdef ARC4_PT_ASCII_CHECK_EN
      logic [7:0] ks [256];
`endif
      for (int x = 0; x < 256; x++) begin
         s_mem[x]  = 8'h00;
         ct_mem[x] = 8'h00;
         pt_mem[x] = 8'h00;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rdy", rdy, 1'b1);
      check("rst_wren", {s_wren, pt_wren}, 2'b00);
      check("rst_addr", {s_addr, ct_addr, pt_addr}, 24'h0);
      check("rst_wrdata", {s_wrdata, pt_wrdata}, 16'h0);
`ifdef ARC4_PT_ASCII_CHECK_EN
      check("rst_pt_ok", pt_ok, 1'b1);
`endif
      rst_n = 1'b0;

      // Identity S, len 49, ct all 49, en held for 2 cycles
      for (int x = 0; x < 256; x++) begin
         init_s[x] = 8'(x);
         ct_mem[x] = 8'd49;
      end
      do_load();
      model_run();
      check("model_pt1", exp_pt[1], 8'h33);
      check("model_pt2", exp_pt[2], 8'h34);
      check("model_pt3", exp_pt[3], 8'h36);
      arm();
      run(2, 2000, "ident", cyc);
      check("ident_pt0_lit", pt_mem[0], 8'd49);
      check("ident_pt1_lit", pt_mem[1], 8'h33);
      check("ident_pt2_lit", pt_mem[2], 8'h34);
      check("ident_pt3_lit", pt_mem[3], 8'h36);
      check("ident_s1_after_step1", snap_s1, 8'd1);
      check("ident_s2_after_step2", snap_s2, 8'd3);
      check("ident_s3_after_step2", snap_s3, 8'd2);
      check_all("ident");
      repeat (10) @(negedge clk);
      check("ident_rdy_stays", rdy, 1'b1);
      check("ident_no_late_writes", wr_idx, 50);

      // len = 0
      for (int x = 0; x < 256; x++) begin
         init_s[x] = 8'($urandom_range(0, 255));
         ct_mem[x] = 8'($urandom_range(0, 255));
      end
      ct_mem[0] = 8'd0;
      do_load();
      model_run();
      arm();
      run(1, 20, "len0", cyc);
      check("len0_latency_le5", (cyc <= 5), 1'b1);
      check("len0_s_writes", s_wr_cnt, 0);
      check_all("len0");

      // len = 255, random S and ct
      for (int x = 0; x < 256; x++) begin
         init_s[x] = 8'($urandom_range(0, 255));
         ct_mem[x] = 8'($urandom_range(0, 255));
      end
      ct_mem[0] = 8'd255;
      do_load();
      model_run();
      arm();
      run(1, 4000, "len255", cyc);
      check_all("len255");

      // Reset in the middle of a run, then rerun from a reloaded S
      for (int x = 0; x < 256; x++) begin
         init_s[x] = 8'($urandom_range(0, 255));
         ct_mem[x] = 8'($urandom_range(0, 255));
      end
      ct_mem[0] = 8'd40;
      do_load();
      model_run();
      arm();
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      cyc = 0;
      while (!(pt_wren === 1'b1 && pt_addr == 8'd10) && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("midrst_reached_k10", (cyc < 1000), 1'b1);
      #2;
      rst_n = 1'b1;
      #1;
      check("midrst_rdy", rdy, 1'b1);
      check("midrst_wren", {s_wren, pt_wren}, 2'b00);
      chk_on = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      do_load();
      model_run();
      arm();
      run(1, 2000, "after_rst", cyc);
      check_all("after_rst");

`ifdef ARC4_PT_ASCII_CHECK_EN
      // Printable plaintext keeps pt_ok=1; a single 0x0A clears it
      for (int x = 0; x < 256; x++) begin
         init_s[x] = 8'(x);
         ct_mem[x] = 8'h00;
      end
      ct_mem[0] = 8'd20;
      model_run();
      for (int x = 1; x <= 20; x++) begin
         ks[x]     = exp_pt[x];
         ct_mem[x] = ks[x] ^ 8'h41;
      end
      do_load();
      model_run();
      arm();
      run(1, 2000, "ascii_ok", cyc);
      check_all("ascii_ok");
      check("ascii_pt_ok_1", pt_ok, 1'b1);

      ct_mem[5] = ks[5] ^ 8'h0A;
      do_load();
      model_run();
      check("ascii_model_pt5", exp_pt[5], 8'h0A);
      arm();
      run(1, 2000, "ascii_bad", cyc);
      check_all("ascii_bad");
      check("ascii_pt_ok_0", pt_ok, 1'b0);
`endif

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arc4_prga.md
Name: arc4_prga

Overview:
- ARC4 pseudo-random generation and XOR stage of the ARC4 decrypt/crack datapath.
- Runs after the key-schedule block has left a permuted state array in S memory.
- Walks the length-prefixed ciphertext in CT memory, updates S in place, and writes the length-prefixed plaintext into PT memory.
- Uses the rdy/en handshake shared by all ARC4 stages.

Parameters:
- none (all widths fixed at 8-bit data/address, 256-entry memories)

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset. Asynchronous, active-high (asserted when 1); name kept per codebase convention.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  1 = idle and able to accept en.
- key  in  24  cipher key; unused by this stage, present for interface uniformity.
- s_addr  out  8  S memory address.
- s_rddata  in  8  S read data, valid 1 cycle after s_addr.
- s_wrdata  out  8  S write data.
- s_wren  out  1  S write enable.
- ct_addr  out  8  CT memory address.
- ct_rddata  in  8  CT read data, 1-cycle latency.
- pt_addr  out  8  PT memory address.
- pt_rddata  in  8  PT read data; unused.
- pt_wrdata  out  8  PT write data.
- pt_wren  out  1  PT write enable.

Behaviour:
- Reset: async, state=IDLE; rdy=1; s_wren=pt_wren=0; all addresses/wrdata=0; i=j=k=0.
- Memories are synchronous-read: the address is presented in cycle N and data is used in cycle N+1.
- Writes take effect with addr/wrdata/wren held for exactly one cycle. wren is never high outside a write cycle.
- Handshake:
  - en with rdy=1 starts the operation; rdy drops the next cycle.
  - en while rdy=0 is ignored; en held high across the start causes no second start.
  - rdy returns to 1 when the last PT write completes and stays 1 until the next en.
- Algorithm, with all arithmetic mod 256 (8-bit wrap):
  - Read ct[0] to get len, write pt[0]=len, set i=j=0.
  - For k=1..len:
    - i=i+1; read s[i].
    - j=j+s[i]; read s[j].
    - write s[i]=old s[j], then write s[j]=old s[i].
    - read s[(si+sj)] to get pad; read ct[k].
    - write pt[k]=pad XOR ct[k].
- Register the values of s[i] and s[j] as they are read; the pad index uses those registered values, not a re-read.
- The swap uses two separate write cycles. When i==j both writes store the same value.
- FSM states: IDLE, RD_LEN, WR_LEN, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, RD_CT, WR_PT. Per byte the path is RD_SI → RD_SJ → WR_SI → WR_SJ → RD_PAD → RD_CT → WR_PT; each read state includes its wait cycle.
- After WR_PT: if k==len go to IDLE, else return to RD_SI. The k counter is 9 bits or compared before increment, so len=255 terminates.
- len=0: only pt[0]=0 is written, then IDLE; S is unmodified.
- Reset mid-operation: immediate return to IDLE with rdy=1 and wren=0. Partial S/PT contents are left as-is.
- No S initialisation is done here; S is consumed as found.

Optional Feature:
- Macro ARC4_PT_ASCII_CHECK_EN.
- When defined: adds output pt_ok (1 bit).
  - Cleared to 1 at start.
  - Forced to 0 if any plaintext byte k≥1 is outside 0x20..0x7E.
  - Valid while rdy=1; reset value 1.
  - Used by the crack controller to reject keys.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package arc4_pkg:
  - state enum type.
  - constants MEM_DEPTH=256, ASCII_LO=8'h20, ASCII_HI=8'h7E.
- One natural sub-module: arc4_mem_rd_seq, a small address-issue / data-capture helper for 1-cycle-latency reads.
- The inline FSM is also acceptable.

Test Plan:
- Identity S (s[x]=x), ct[0]=49, ct[k]=49 for all k, pulse en for 2 cycles:
  - pt[0]=49, pt[1]=0x33, pt[2]=0x34, pt[3]=0x36.
  - Exactly one start; rdy returns to 1 after pt[49] is written; no writes afterwards.
- Same setup: S after completion matches a software ARC4 model; s[1] is untouched by the i=j=1 swap; after step 2, s[2]=3 and s[3]=2.
- ct[0]=0: pt[0]=0, zero S writes, rdy back to 1 within 5 cycles.
- ct[0]=255, random S and ct: full PT matches the software model; no address overflow; terminates.
- Assert rst_n mid-run at k=10: rdy=1 and wren=0 immediately (async). A fresh en then produces correct output from a reloaded S.
- ARC4_PT_ASCII_CHECK_EN: PT all in 0x20..0x7E gives pt_ok=1; inject one byte 0x0A gives pt_ok=0.
